// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the CPU front end. Holds the default
//               instruction/address widths, the default prefetch depth, the
//               default reset fetch address and the fetch entry record that
//               pairs an instruction word with the address it came from.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int          c_ROM_DATA_WIDTH = 16;
    localparam int          c_ROM_ADDR_WIDTH = 12;
    localparam int          c_FIFO_DEPTH     = 4;
    localparam int unsigned c_RESET_ADDR     = 0;

    // One prefetched instruction together with its word address.
    typedef struct packed {
        logic [c_ROM_DATA_WIDTH-1:0] inst;
        logic [c_ROM_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Show-ahead FIFO for prefetched instruction entries. The head
//               entry is visible combinationally from storage. Push and pop
//               may happen in the same cycle at any fill level. Flush has
//               priority over push and pop and empties the FIFO.
// Ports       : i_clk        clock, rising edge
//               i_rst        synchronous reset, active low
//               i_flush      discard all entries this edge
//               i_push       write i_push_data at the tail
//               i_push_data  entry to write
//               i_pop        retire the head entry (ignored when empty)
//               o_head_data  head entry (show-ahead)
//               o_valid      FIFO holds at least one entry
//               o_count      number of entries held, 0..DEPTH
// Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop;

    // A pop against an empty FIFO is dropped so the count never underflows.
    assign w_pop = i_pop & (r_count != '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(i_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge i_clk) begin
        if (i_rst && !i_flush && i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_valid     = (r_count != '0);
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Owns the program counter, drives the
//               synchronous ROM address, captures returned words into a
//               prefetch FIFO and hands them to decode over valid/ready.
//               A redirect flushes buffered and in-flight words and restarts
//               fetch at a new address.
// Ports       : i_clk            clock, rising edge
//               i_rst            synchronous reset, active low
//               rom_addr         registered ROM word address
//               rom_din          ROM data, valid one cycle after address
//               i_redirect       single-cycle flush-and-jump request
//               i_redirect_addr  new fetch address
//               o_inst_valid     head instruction valid
//               o_inst           head instruction word
//               o_inst_pc        address of head instruction
//               i_inst_ready     decode accepts head this cycle
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int          ROM_DATA_WIDTH = c_ROM_DATA_WIDTH,
    parameter int          ROM_ADDR_WIDTH = c_ROM_ADDR_WIDTH,
    parameter int          FIFO_DEPTH     = c_FIFO_DEPTH,
    parameter int unsigned RESET_ADDR     = c_RESET_ADDR
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [ROM_DATA_WIDTH-1:0] rom_din,
    input  logic                      i_redirect,
    input  logic [ROM_ADDR_WIDTH-1:0] i_redirect_addr,
    output logic                      o_inst_valid,
    output logic [ROM_DATA_WIDTH-1:0] o_inst,
    output logic [ROM_ADDR_WIDTH-1:0] o_inst_pc,
    input  logic                      i_inst_ready
);

    localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_OCC_W   = c_CNT_W + 1;
    localparam int c_ENTRY_W = ROM_DATA_WIDTH + ROM_ADDR_WIDTH;
    localparam logic [ROM_ADDR_WIDTH-1:0] c_RESET_PC = ROM_ADDR_WIDTH'(RESET_ADDR);

    logic [ROM_ADDR_WIDTH-1:0] r_fetch_pc;
    logic                      r_inflight;
    logic [ROM_ADDR_WIDTH-1:0] r_issued_pc;

    logic [ROM_ADDR_WIDTH-1:0] w_fetch_pc_d;
    logic                      w_inflight_d;
    logic [ROM_ADDR_WIDTH-1:0] w_issued_pc_d;

    logic                      w_pop;
    logic                      w_issue;
    logic [c_OCC_W-1:0]        w_occ;
    logic [c_CNT_W-1:0]        w_count;
    logic                      w_fifo_valid;
    logic [c_ENTRY_W-1:0]      w_head;

    assign w_pop = w_fifo_valid & i_inst_ready;

    // Slots that will be spoken for after this edge: what stays buffered
    // plus the word still on its way back from the ROM. A pop can only occur
    // with a non-empty FIFO, so the subtraction never wraps.
    assign w_occ   = c_OCC_W'(w_count) + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_issue = (w_occ < c_OCC_W'(FIFO_DEPTH));

    always_comb begin
        w_fetch_pc_d  = r_fetch_pc;
        w_inflight_d  = 1'b0;
        w_issued_pc_d = r_issued_pc;
        if (i_redirect) begin
            // The outstanding ROM read is abandoned; its data is not captured.
            w_fetch_pc_d = i_redirect_addr;
        end else if (w_issue) begin
            w_inflight_d  = 1'b1;
            w_issued_pc_d = r_fetch_pc;
            w_fetch_pc_d  = r_fetch_pc + ROM_ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_fetch_pc  <= c_RESET_PC;
            r_inflight  <= 1'b0;
            r_issued_pc <= '0;
        end else begin
            r_fetch_pc  <= w_fetch_pc_d;
            r_inflight  <= w_inflight_d;
            r_issued_pc <= w_issued_pc_d;
        end
    end

    // The word for an issued address is on rom_din during the following
    // cycle, so an in-flight flag at an edge means "capture now".
    fetch_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_redirect),
        .i_push      (r_inflight),
        .i_push_data ({rom_din, r_issued_pc}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_count)
    );

    assign rom_addr     = r_fetch_pc;
    assign o_inst_valid = w_fifo_valid;
    // Stale storage is hidden so an empty FIFO presents zeros.
    assign o_inst       = w_fifo_valid ? w_head[c_ENTRY_W-1:ROM_ADDR_WIDTH] : '0;
    assign o_inst_pc    = w_fifo_valid ? w_head[ROM_ADDR_WIDTH-1:0]         : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A synchronous ROM model
//               returns 0x1000+address. A queue-based reference model tracks
//               buffered instruction addresses, the outstanding ROM read and
//               the next fetch address, and every cycle the DUT outputs are
//               compared against it. Directed scenarios are followed by a
//               randomized phase with random ready, redirects and resets.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int c_DW    = 16;
    localparam int c_AW    = 12;
    localparam int c_DEPTH = 4;

    logic              clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_redirect = 1'b0;
    logic [c_AW-1:0]   i_redirect_addr = '0;
    logic              i_inst_ready = 1'b0;
    logic [c_AW-1:0]   rom_addr;
    logic [c_DW-1:0]   rom_din;
    logic              o_inst_valid;
    logic [c_DW-1:0]   o_inst;
    logic [c_AW-1:0]   o_inst_pc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [c_AW-1:0]   m_q[$];
    logic              m_inflight = 1'b0;
    logic [c_AW-1:0]   m_inflight_pc = '0;
    logic [c_AW-1:0]   m_next_pc = '0;

    always #5 clk = ~clk;

    instr_fetch #(
        .ROM_DATA_WIDTH (c_DW),
        .ROM_ADDR_WIDTH (c_AW),
        .FIFO_DEPTH     (c_DEPTH),
        .RESET_ADDR     (0)
    ) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .rom_addr        (rom_addr),
        .rom_din         (rom_din),
        .i_redirect      (i_redirect),
        .i_redirect_addr (i_redirect_addr),
        .o_inst_valid    (o_inst_valid),
        .o_inst          (o_inst),
        .o_inst_pc       (o_inst_pc),
        .i_inst_ready    (i_inst_ready)
    );

    function automatic logic [c_DW-1:0] rom_word(input logic [c_AW-1:0] a);
        return 16'h1000 + {4'b0, a};
    endfunction

    // Synchronous ROM: data for the sampled address one cycle later.
    always @(posedge clk) rom_din <= rom_word(rom_addr);

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour at one rising edge, from the block's rules.
    task automatic model_edge();
        bit pop, issue;
        int occ;
        if (!i_rst) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_next_pc  = '0;
        end else if (i_redirect) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_next_pc  = i_redirect_addr;
        end else begin
            pop   = (m_q.size() != 0) && i_inst_ready;
            occ   = m_q.size() - int'(pop) + int'(m_inflight);
            issue = (occ < c_DEPTH);
            if (pop) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(m_inflight_pc);
            m_inflight = issue;
            if (issue) begin
                m_inflight_pc = m_next_pc;
                m_next_pc     = m_next_pc + 12'd1;
            end
        end
    endtask

    task automatic compare_outputs();
        check_value("valid", 32'(o_inst_valid), 32'(m_q.size() != 0));
        check_value("rom_addr", 32'(rom_addr), 32'(m_next_pc));
        check_value("count", 32'(dut.u_fifo.o_count), 32'(m_q.size()));
        if (m_q.size() != 0) begin
            check_value("inst_pc", 32'(o_inst_pc), 32'(m_q[0]));
            check_value("inst", 32'(o_inst), 32'(rom_word(m_q[0])));
        end
    endtask

    // Apply inputs for one cycle, advance both DUT and model, then compare.
    task automatic cycle(input logic rst_n, input logic red,
                         input logic [c_AW-1:0] raddr, input logic rdy);
        i_rst           = rst_n;
        i_redirect      = red;
        i_redirect_addr = raddr;
        i_inst_ready    = rdy;
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    initial begin
        fetch_entry_t head;
        logic [c_AW-1:0] ra;

        // Scenario: reset release and streaming with ready high
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_value("rst_inst", 32'(o_inst), 32'h0);
        check_value("rst_pc", 32'(o_inst_pc), 32'h0);
        check_value("rst_valid", 32'(o_inst_valid), 32'h0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_value("e0_valid", 32'(o_inst_valid), 32'h0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        head = {o_inst, o_inst_pc};
        check_value("e1_inst", 32'(head.inst), 32'h1000);
        check_value("e1_pc", 32'(head.pc), 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b1);

        // Scenario: backpressure fills the FIFO, then drain in order
        cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        check_value("stall_addr", 32'(rom_addr), 32'd4);
        check_value("stall_pc", 32'(o_inst_pc), 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b1);

        // Scenario: redirect with three buffered entries and one in flight
        cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 12'h200, 1'b0);
        check_value("redir_v0", 32'(o_inst_valid), 32'h0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_value("redir_v1", 32'(o_inst_valid), 32'h0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_value("redir_pc", 32'(o_inst_pc), 32'h200);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1);

        // Scenario: redirect across the top of the address space
        cycle(1'b1, 1'b1, 12'hFFE, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b1);

        // Scenario: redirect in the same cycle as a pop with FIFO full
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        check_value("full_count", 32'(dut.u_fifo.o_count), 32'd4);
        cycle(1'b1, 1'b1, 12'h345, 1'b1);
        check_value("flush_count", 32'(dut.u_fifo.o_count), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1);

        // Scenario: reset pulse mid-stream with FIFO partly full
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 12'h123, 1'b1);
        check_value("mid_rst_addr", 32'(rom_addr), 32'h0);
        check_value("mid_rst_inst", 32'(o_inst), 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b1);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic rst_n, red, rdy;
            rst_n = ($urandom_range(0, 299) != 0);
            red   = ($urandom_range(0, 39) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                ra = 12'hFF0 + 12'($urandom_range(0, 15));
            else
                ra = 12'($urandom_range(0, 4095));
            cycle(rst_n, red, ra, rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
